// File: rtl/wb_pipelined_slave_if.sv
// Wishbone pipelined-mode bus bundle between a master and the RAM-backed responder.
// The master drives the request side; the slave drives the ack/err/read-data side.
interface wb_pipelined_slave_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 16
);
    logic [ADDR_WIDTH-1:0] adr;
    logic [DATA_WIDTH-1:0] datWr;
    logic [DATA_WIDTH-1:0] datRd;
    logic                  cyc;
    logic                  stb;
    logic                  we;
    logic                  ack;
    logic                  err;

    modport master (
        output adr, datWr, cyc, stb, we,
        input  datRd, ack, err
    );

    modport slave (
        input  adr, datWr, cyc, stb, we,
        output datRd, ack, err
    );
endinterface

// File: rtl/wb_pipelined_slave.sv
// Wishbone pipelined responder over a local word RAM: one request per clock, never
// stalls, and answers each request with ack or err a fixed LATENCY cycles later.
module wb_pipelined_slave #(
    parameter int                    ADDR_WIDTH = 16,
    parameter int                    DATA_WIDTH = 16,
    parameter int                    MEM_AW     = 8,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
    parameter int                    LATENCY    = 2
) (
    input  logic                clk_i,
    input  logic                reset_i,
    wb_pipelined_slave_if.slave bus
);

    typedef struct packed {
        logic                  valid;
        logic                  hit;
        logic                  we;
        logic [DATA_WIDTH-1:0] rdata;
    } entry_t;

    logic [DATA_WIDTH-1:0] mem_q [0:(1<<MEM_AW)-1];
    entry_t                pipe_q [LATENCY];
    entry_t                pipe_d [LATENCY];
    logic [DATA_WIDTH-1:0] lastDat_q;

    logic                  accept;
    logic                  hit;
    logic [MEM_AW-1:0]     index;
    logic                  ackOut;
    logic                  errOut;
    logic                  readOut;
    logic [DATA_WIDTH-1:0] datOut;

    assign accept = bus.cyc & bus.stb;
    assign hit    = (bus.adr[ADDR_WIDTH-1:MEM_AW] == BASE_ADDR[ADDR_WIDTH-1:MEM_AW]);
    assign index  = bus.adr[MEM_AW-1:0];

    // Stage 0 takes the new request; dropping cyc kills every in-flight entry.
    always_comb begin
        pipe_d[0].valid = accept;
        pipe_d[0].hit   = hit;
        pipe_d[0].we    = bus.we;
        pipe_d[0].rdata = (hit && !bus.we) ? mem_q[index] : '0;
        for (int k = 1; k < LATENCY; k++) begin
            pipe_d[k] = pipe_q[k-1];
        end
        if (!bus.cyc) begin
            for (int k = 0; k < LATENCY; k++) begin
                pipe_d[k].valid = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            for (int k = 0; k < LATENCY; k++) begin
                pipe_q[k] <= '0;
            end
            lastDat_q <= '0;
        end else begin
            for (int k = 0; k < LATENCY; k++) begin
                pipe_q[k] <= pipe_d[k];
            end
            lastDat_q <= datOut;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i && accept && hit && bus.we) begin
            mem_q[index] <= bus.datWr;
        end
    end

    // Responses are only shown while the cycle is live, so an abort suppresses them at once.
    assign ackOut  = bus.cyc & pipe_q[LATENCY-1].valid &  pipe_q[LATENCY-1].hit;
    assign errOut  = bus.cyc & pipe_q[LATENCY-1].valid & ~pipe_q[LATENCY-1].hit;
    assign readOut = bus.cyc & pipe_q[LATENCY-1].valid & ~pipe_q[LATENCY-1].we;
    assign datOut  = readOut ? pipe_q[LATENCY-1].rdata : lastDat_q;

    assign bus.ack   = ackOut;
    assign bus.err   = errOut;
    assign bus.datRd = datOut;

endmodule
